// File: rtl/audioplay_timer_sequencer.sv
// audioplay_timer_sequencer: Avalon-MM master that programs the interval timer used as the
// audio sample-rate clock, acknowledges each timer IRQ and hands every tick to a downstream
// consumer over a valid/ready handshake. It is the only master on the timer slave port.
module audioplay_timer_sequencer #(
    parameter int unsigned TICK_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // Playback control
    input  logic                  start,
    input  logic                  stop,
    input  logic [31:0]           interval_cycles,
    output logic                  busy,
    // Tick stream towards the consumer
    output logic                  tick_valid,
    input  logic                  tick_ready,
    output logic                  overrun,
    output logic [TICK_CNT_W-1:0] tick_count,
    // Timer slave port
    output logic [2:0]            tmr_address,
    output logic                  tmr_chipselect,
    output logic                  tmr_write_n,
    output logic [15:0]           tmr_writedata,
    input  logic                  tmr_irq
);

    // Timer register map and control words
    localparam logic [2:0]  AddrStatus  = 3'd0;
    localparam logic [2:0]  AddrControl = 3'd1;
    localparam logic [2:0]  AddrPeriodL = 3'd2;
    localparam logic [2:0]  AddrPeriodH = 3'd3;
    localparam logic [15:0] CtrlRun     = 16'h0007;  // START | CONT | ITO
    localparam logic [15:0] CtrlStop    = 16'h0008;  // STOP, interrupts disabled
    localparam logic [15:0] StatusClear = 16'h0000;

    typedef enum logic [2:0] {
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtrl,
        StRun,
        StAck,
        StWrStop,
        StClr
    } state_e;

    state_e                state_q;
    logic [31:0]           period_q;
    logic                  stop_pend_q;
    logic                  busy_q;
    logic                  tick_valid_q;
    logic                  overrun_q;
    logic [TICK_CNT_W-1:0] tick_count_q;
    logic [2:0]            tmr_addr_q;
    logic                  tmr_cs_q;
    logic                  tmr_wn_q;
    logic [15:0]           tmr_wdata_q;

    logic [31:0]           period_start;

    // Period value loaded into the timer; it counts P..0, so P = interval - 1, floored at 1.
    always_comb begin
        period_start = 32'd1;
        if (interval_cycles > 32'd2) begin
            period_start = interval_cycles - 32'd1;
        end
    end

    // Sequencer FSM; all outputs are registered and change together with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            period_q     <= '0;
            stop_pend_q  <= 1'b0;
            busy_q       <= 1'b0;
            tick_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            tick_count_q <= '0;
            tmr_addr_q   <= '0;
            tmr_cs_q     <= 1'b0;
            tmr_wn_q     <= 1'b1;
            tmr_wdata_q  <= '0;
        end else begin
            // Bus idles unless the next state is a write state.
            tmr_cs_q    <= 1'b0;
            tmr_wn_q    <= 1'b1;
            tmr_addr_q  <= '0;
            tmr_wdata_q <= '0;

            // Consumer handshake; a new tick set below overrides this clear.
            if (tick_valid_q && tick_ready) begin
                tick_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        period_q     <= period_start;
                        overrun_q    <= 1'b0;
                        tick_count_q <= '0;
                        stop_pend_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= StWrPl;
                        tmr_cs_q     <= 1'b1;
                        tmr_wn_q     <= 1'b0;
                        tmr_addr_q   <= AddrPeriodL;
                        tmr_wdata_q  <= period_start[15:0];
                    end
                end

                StWrPl: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    state_q     <= StWrPh;
                    tmr_cs_q    <= 1'b1;
                    tmr_wn_q    <= 1'b0;
                    tmr_addr_q  <= AddrPeriodH;
                    tmr_wdata_q <= period_q[31:16];
                end

                StWrPh: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    state_q     <= StWrCtrl;
                    tmr_cs_q    <= 1'b1;
                    tmr_wn_q    <= 1'b0;
                    tmr_addr_q  <= AddrControl;
                    tmr_wdata_q <= CtrlRun;
                end

                StWrCtrl: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    state_q <= StRun;
                end

                StRun: begin
                    // Stop beats a coincident IRQ; that tick is dropped.
                    if (stop || stop_pend_q) begin
                        state_q     <= StWrStop;
                        tmr_cs_q    <= 1'b1;
                        tmr_wn_q    <= 1'b0;
                        tmr_addr_q  <= AddrControl;
                        tmr_wdata_q <= CtrlStop;
                    end else if (tmr_irq) begin
                        state_q      <= StAck;
                        tmr_cs_q     <= 1'b1;
                        tmr_wn_q     <= 1'b0;
                        tmr_addr_q   <= AddrStatus;
                        tmr_wdata_q  <= StatusClear;
                        tick_count_q <= tick_count_q + TICK_CNT_W'(1);
                        tick_valid_q <= 1'b1;
                        if (tick_valid_q && !tick_ready) begin
                            overrun_q <= 1'b1;
                        end
                    end
                end

                StAck: begin
                    // A stop seen here is deferred to the next RUN cycle rather than lost.
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    state_q <= StRun;
                end

                StWrStop: begin
                    state_q     <= StClr;
                    tmr_cs_q    <= 1'b1;
                    tmr_wn_q    <= 1'b0;
                    tmr_addr_q  <= AddrStatus;
                    tmr_wdata_q <= StatusClear;
                end

                StClr: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign tick_valid     = tick_valid_q;
    assign overrun        = overrun_q;
    assign tick_count     = tick_count_q;
    assign tmr_address    = tmr_addr_q;
    assign tmr_chipselect = tmr_cs_q;
    assign tmr_write_n    = tmr_wn_q;
    assign tmr_writedata  = tmr_wdata_q;

endmodule

// File: tb/tb_audioplay_timer_sequencer.sv
// Self-checking bench for audioplay_timer_sequencer: a behavioural interval-timer slave plus
// a tick-schedule reference model derived from the programmed interval.
module tb_audioplay_timer_sequencer;

    localparam int unsigned CntW = 32;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            stop;
    logic [31:0]     interval_cycles;
    logic            busy;
    logic            tick_valid;
    logic            tick_ready;
    logic            overrun;
    logic [CntW-1:0] tick_count;
    logic [2:0]      tmr_address;
    logic            tmr_chipselect;
    logic            tmr_write_n;
    logic [15:0]     tmr_writedata;
    logic            tmr_irq;

    int n_cmp = 0;
    int n_err = 0;
    bit m_pend = 1'b0;  // reference: a tick is pending for the consumer

    always #5 clk = ~clk;

    audioplay_timer_sequencer #(
        .TICK_CNT_W(CntW)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .stop           (stop),
        .interval_cycles(interval_cycles),
        .busy           (busy),
        .tick_valid     (tick_valid),
        .tick_ready     (tick_ready),
        .overrun        (overrun),
        .tick_count     (tick_count),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural interval timer: 32-bit period split over two 16-bit registers, counts
    // period..0 and raises the timeout flag on reaching zero, reloading in continuous mode.
    logic [31:0] t_per;
    logic [31:0] t_cnt;
    logic        t_run;
    logic        t_to;
    logic        t_ito;
    logic        t_wr;

    assign t_wr    = tmr_chipselect && !tmr_write_n;
    assign tmr_irq = t_to && t_ito;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_per <= '0;
            t_cnt <= '0;
            t_run <= 1'b0;
            t_to  <= 1'b0;
            t_ito <= 1'b0;
        end else begin
            if (t_wr && tmr_address == 3'd0) t_to <= 1'b0;
            if (t_wr && tmr_address == 3'd2) t_per[15:0] <= tmr_writedata;
            if (t_wr && tmr_address == 3'd3) t_per[31:16] <= tmr_writedata;
            if (t_wr && tmr_address == 3'd1) begin
                t_ito <= tmr_writedata[0];
                if (tmr_writedata[3]) begin
                    t_run <= 1'b0;
                end else if (tmr_writedata[2]) begin
                    t_run <= 1'b1;
                    t_cnt <= t_per;
                end
            end else if (t_run) begin
                if (t_cnt == 32'd0) begin
                    t_to  <= 1'b1;  // timeout beats a same-edge status clear
                    t_cnt <= t_per;
                end else begin
                    t_cnt <= t_cnt - 32'd1;
                end
            end
        end
    end

    // Record every bus write as {address, data}.
    logic [18:0] obs_wr[$];

    always @(posedge clk) begin
        if (t_wr) obs_wr.push_back({tmr_address, tmr_writedata});
    end

    always @(negedge clk) begin
        check_eq("cs_vs_write_n", 64'(tmr_write_n), 64'(!tmr_chipselect));
    end

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_tick_valid"}, 64'(tick_valid), 64'd0);
        check_eq({tag, "_overrun"}, 64'(overrun), 64'd0);
        check_eq({tag, "_tick_count"}, 64'(tick_count), 64'd0);
        check_eq({tag, "_cs"}, 64'(tmr_chipselect), 64'd0);
        check_eq({tag, "_write_n"}, 64'(tmr_write_n), 64'd1);
        check_eq({tag, "_address"}, 64'(tmr_address), 64'd0);
        check_eq({tag, "_writedata"}, 64'(tmr_writedata), 64'd0);
    endtask

    // One start..stop session. Ticks are acknowledged at cycles 5 + k*I (k = 1..nticks);
    // stop is issued in the RUN cycle after the last one (or at cycle 4 when no ticks),
    // or during WR_PH when early is set.
    task automatic run_scenario(input logic [31:0] ival, input int nticks, input int ready_pct,
                                input bit early, input bit stop_with_start);
        longint      ieff;
        longint      s;
        longint      nc;
        logic [31:0] p;
        logic [18:0] exp_wr[$];
        int          m_cnt;
        bit          m_ovr;
        bit          rdy;
        bit          acc;
        bit          is_ack;
        int          n;

        ieff = (ival < 32'd2) ? 64'd2 : longint'(ival);
        p    = 32'(ieff - 1);
        s    = (early || nticks == 0) ? 64'd4 : 64'd5 + ieff * longint'(nticks) + 64'd1;
        exp_wr = {};
        exp_wr.push_back({3'd2, p[15:0]});
        exp_wr.push_back({3'd3, p[31:16]});
        exp_wr.push_back({3'd1, 16'h0007});
        obs_wr.delete();

        @(negedge clk);
        start           = 1'b1;
        stop            = stop_with_start;
        interval_cycles = ival;
        tick_ready      = 1'b0;
        m_cnt           = 0;
        m_ovr           = 1'b0;

        for (longint c = 1; c <= s + 6; c++) begin
            @(negedge clk);
            start           = 1'b0;
            stop            = 1'b0;
            interval_cycles = $urandom();
            check_eq("busy", 64'(busy), 64'(c <= s + 2));
            check_eq("tick_valid", 64'(tick_valid), 64'(m_pend));
            check_eq("tick_count", 64'(tick_count), 64'(m_cnt));
            check_eq("overrun", 64'(overrun), 64'(m_ovr));
            if (early && c == 2) stop = 1'b1;
            if (!early && c == s) stop = 1'b1;
            if (c == 4 || c == s + 1) start = 1'b1;  // busy: must be ignored
            rdy        = ($urandom_range(0, 99) < ready_pct);
            tick_ready = rdy;
            nc         = c + 1;
            is_ack = !early && nticks > 0 && nc >= 5 + ieff && nc <= s && ((nc - 5) % ieff == 0);
            acc    = m_pend && rdy;
            if (is_ack) begin
                if (m_pend && !acc) m_ovr = 1'b1;
                m_pend = 1'b1;
                m_cnt++;
                exp_wr.push_back({3'd0, 16'h0000});
            end else if (acc) begin
                m_pend = 1'b0;
            end
        end

        exp_wr.push_back({3'd1, 16'h0008});
        exp_wr.push_back({3'd0, 16'h0000});
        check_eq("write_count", 64'(obs_wr.size()), 64'(exp_wr.size()));
        n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) begin
            check_eq("write_addr_data", 64'(obs_wr[i]), 64'(exp_wr[i]));
        end
    endtask

    // Reset while running interval 7 with the consumer stalled: acks at 12 and 19.
    task automatic reset_mid();
        obs_wr.delete();
        @(negedge clk);
        start           = 1'b1;
        interval_cycles = 32'd7;
        tick_ready      = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check_eq("pre_reset_tick_count", 64'(tick_count), 64'd2);
        check_eq("pre_reset_tick_valid", 64'(tick_valid), 64'd1);
        check_eq("pre_reset_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1 check_reset_values("async_reset");
        check_eq("reset_writes", 64'(obs_wr.size()), 64'd5);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("post_reset_writes", 64'(obs_wr.size()), 64'd5);
        check_eq("post_reset_busy", 64'(busy), 64'd0);
        m_pend = 1'b0;
    endtask

    initial begin
        reset_n         = 1'b1;
        start           = 1'b0;
        stop            = 1'b0;
        tick_ready      = 1'b0;
        interval_cycles = '0;
        #1 reset_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_scenario(32'd1000, 0, 100, 1'b0, 1'b0);
        run_scenario(32'h0001_2345, 0, 100, 1'b0, 1'b0);
        run_scenario(32'd0, 0, 100, 1'b0, 1'b0);
        run_scenario(32'd1, 0, 100, 1'b0, 1'b0);
        run_scenario(32'd50, 20, 100, 1'b0, 1'b0);
        run_scenario(32'd9, 2, 0, 1'b0, 1'b0);
        run_scenario(32'd6, 3, 100, 1'b0, 1'b0);
        run_scenario(32'h0000_ABCD, 0, 50, 1'b1, 1'b0);
        run_scenario(32'd2, 6, 50, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            run_scenario(32'($urandom_range(2, 12)), int'($urandom_range(1, 10)),
                         int'($urandom_range(20, 80)), 1'b0, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) begin
            run_scenario($urandom(), 0, 50, 1'b0, 1'b0);
        end
        reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
